// File: rtl/i2s_dac_tx.sv
// Philips I2S transmitter for the codec DAC: one mono sample per frame, sent
// MSB first on both channels with the standard one-BCLK data delay.
module i2s_dac_tx #(
    parameter int SAMPLE_W = 16,
    parameter int BCLK_DIV = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic                sample_ack,
    output logic                AUD_BCLK,
    output logic                AUD_DACLRCK,
    output logic                AUD_DACDAT,
    output logic                busy,
    output logic                underrun
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int CNT_W = $clog2(2 * SAMPLE_W);
    localparam int IDX_W = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(2 * SAMPLE_W - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state, state_nxt;
    logic [DIV_W-1:0]    div_cnt, div_cnt_nxt;
    logic [CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
    logic [SAMPLE_W-1:0] word, word_nxt;
    logic                prev_lsb, prev_lsb_nxt;
    logic                bclk, bclk_nxt;
    logic                lrck, lrck_nxt;
    logic                dat, dat_nxt;
    logic                ack, ack_nxt;
    logic                urun, urun_nxt;

    logic [CNT_W-1:0]    bit_new;
    logic [CNT_W-1:0]    pos;
    logic                slot_right;
    logic [IDX_W-1:0]    idx;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            word     <= '0;
            prev_lsb <= 1'b0;
            bclk     <= 1'b0;
            lrck     <= 1'b0;
            dat      <= 1'b0;
            ack      <= 1'b0;
            urun     <= 1'b0;
        end else begin
            state    <= state_nxt;
            div_cnt  <= div_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            word     <= word_nxt;
            prev_lsb <= prev_lsb_nxt;
            bclk     <= bclk_nxt;
            lrck     <= lrck_nxt;
            dat      <= dat_nxt;
            ack      <= ack_nxt;
            urun     <= urun_nxt;
        end
    end

    // Slot position after the next BCLK fall; p=0 replays the previous slot's LSB.
    always_comb begin
        bit_new    = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CNT_W'(1);
        slot_right = (bit_new >= CNT_W'(SAMPLE_W));
        pos        = slot_right ? bit_new - CNT_W'(SAMPLE_W) : bit_new;
        idx        = (pos == '0) ? '0 : IDX_W'(SAMPLE_W - int'(pos));
    end

    always_comb begin
        state_nxt    = state;
        div_cnt_nxt  = div_cnt;
        bit_cnt_nxt  = bit_cnt;
        word_nxt     = word;
        prev_lsb_nxt = prev_lsb;
        bclk_nxt     = bclk;
        lrck_nxt     = lrck;
        dat_nxt      = dat;
        ack_nxt      = 1'b0;
        urun_nxt     = urun;

        unique case (state)
            IDLE: begin
                div_cnt_nxt = '0;
                bit_cnt_nxt = '0;
                bclk_nxt    = 1'b0;
                lrck_nxt    = 1'b0;
                dat_nxt     = 1'b0;
                if (enable) begin
                    state_nxt = RUN;
                    dat_nxt   = prev_lsb;
                    if (sample_valid) begin
                        word_nxt = sample_in;
                        ack_nxt  = 1'b1;
                    end else begin
                        urun_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt_nxt = '0;
                    bclk_nxt    = ~bclk;
                    if (bclk) begin
                        bit_cnt_nxt = bit_new;
                        lrck_nxt    = slot_right;
                        dat_nxt     = word[idx];
                        // Disable is only honoured here so a frame is never cut short.
                        if (bit_cnt == LAST_BIT) begin
                            prev_lsb_nxt = word[0];
                            if (enable) begin
                                if (sample_valid) begin
                                    word_nxt = sample_in;
                                    ack_nxt  = 1'b1;
                                end else begin
                                    urun_nxt = 1'b1;
                                end
                            end else begin
                                state_nxt = IDLE;
                                lrck_nxt  = 1'b0;
                                dat_nxt   = 1'b0;
                            end
                        end
                    end
                end else begin
                    div_cnt_nxt = div_cnt + DIV_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign sample_ack  = ack;
    assign AUD_BCLK    = bclk;
    assign AUD_DACLRCK = lrck;
    assign AUD_DACDAT  = dat;
    assign busy        = (state == RUN);
    assign underrun    = urun;

endmodule
